// File: rtl/tlul_host_watchdog_pkg.sv
// TL-UL channel types and helpers shared by the host-port watchdog and its interface.
package tlul_host_watchdog_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_DUW = 7;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DW/8-1:0]  a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic                d_sink;
    logic [TL_DW-1:0]    d_data;
    logic [TL_DUW-1:0]   d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

  function automatic tl_d_op_e rsp_opcode(input tl_a_op_e op);
    return (op == Get) ? AccessAckData : AccessAck;
  endfunction

  // Response integrity: every covered bit is folded into one of the TL_DUW check bits.
  function automatic logic [TL_DUW-1:0] rsp_intg(input tl_d_op_e op,
                                                 input logic [TL_SZW-1:0] size,
                                                 input logic [TL_AIW-1:0] source,
                                                 input logic error,
                                                 input logic [TL_DW-1:0] data);
    logic [3+TL_SZW+TL_AIW+1+TL_DW-1:0] bits;
    logic [TL_DUW-1:0] code;
    bits = {op, size, source, error, data};
    code = '0;
    for (int i = 0; i < $bits(bits); i++) code[i % TL_DUW] ^= bits[i];
    return code;
  endfunction

endpackage

// File: rtl/tlul_host_watchdog_if.sv
// One TL-UL link: master drives the A channel and d_ready, slave drives D and a_ready.
interface tlul_host_watchdog_if;
  import tlul_host_watchdog_pkg::*;

  // A beat transfers when a_valid && a_ready, a D beat when d_valid && d_ready, both at the
  // rising clock edge; a valid, once raised, holds its payload until that handshake.
  tl_h2d_t h2d;
  tl_d2h_t d2h;

  modport master (output h2d, input d2h);
  modport slave  (input h2d, output d2h);
endinterface

// File: rtl/tlul_host_watchdog_fifo.sv
// Synchronous FIFO without pass-through, holding one entry per in-flight request.
module tlul_host_watchdog_fifo #(
  parameter int unsigned Width  = 8,
  parameter int unsigned Depth  = 4,
  localparam int unsigned DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [DepthW-1:0] depth_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [DepthW-1:0] cnt_q;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DepthW'(Depth));
  assign depth_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/tlul_host_watchdog.sv
// Host-port watchdog: caps in-flight TL-UL requests and, once a response hangs, error-responds
// everything until cleared.
module tlul_host_watchdog
  import tlul_host_watchdog_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  tlul_host_watchdog_if.slave                  tl_h,
  tlul_host_watchdog_if.master                 tl_d,
  input  logic                                 clear_i,
  output logic                                 timeout_o,
  output logic                                 fault_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam int unsigned OccW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic [TL_AIW-1:0] source;
    logic [TL_SZW-1:0] size;
    tl_d_op_e          d_op;
  } wd_entry_t;

  typedef enum logic {StActive = 1'b0, StFault = 1'b1} wd_state_e;

  wd_state_e       state_q, state_d;
  logic [CntW-1:0] timer_q, timer_d;
  logic [OccW-1:0] dn_pending_q, dn_pending_d;
  logic            timeout_q, timeout_d;

  wd_entry_t                 push_entry, head;
  logic [$bits(wd_entry_t)-1:0] head_raw;
  logic                      push, pop, full, empty, dn_d_hs, dn_inc;
  tl_h2d_t                   dn_req;
  tl_d2h_t                   up_rsp, fault_rsp;

  assign push_entry = '{source: tl_h.h2d.a_source, size: tl_h.h2d.a_size,
                        d_op: rsp_opcode(tl_h.h2d.a_opcode)};
  assign head       = wd_entry_t'(head_raw);

  tlul_host_watchdog_fifo #(
    .Width ($bits(wd_entry_t)),
    .Depth (MaxOutstanding)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .empty_o (empty),
    .full_o  (full),
    .depth_o (outstanding_o)
  );

  // Error response for the FIFO head, presented to the core while in FAULT.
  always_comb begin
    fault_rsp          = '0;
    fault_rsp.d_valid  = ~empty;
    fault_rsp.d_opcode = head.d_op;
    fault_rsp.d_size   = head.size;
    fault_rsp.d_source = head.source;
    fault_rsp.d_error  = 1'b1;
    fault_rsp.d_data   = '1;
    fault_rsp.d_user   = rsp_intg(head.d_op, head.size, head.source, 1'b1, '1);
    fault_rsp.a_ready  = ~full;
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    dn_pending_d = dn_pending_q;
    timeout_d    = 1'b0;
    dn_req       = tl_h.h2d;
    dn_req.a_valid = 1'b0;
    dn_req.d_ready = 1'b1;
    up_rsp       = fault_rsp;
    push         = 1'b0;
    pop          = 1'b0;
    dn_d_hs      = 1'b0;
    case (state_q)
      StActive: begin
        dn_req.a_valid = tl_h.h2d.a_valid & ~full;
        dn_req.d_ready = tl_h.h2d.d_ready;
        up_rsp         = tl_d.d2h;
        up_rsp.a_ready = tl_d.d2h.a_ready & ~full;
        push    = tl_h.h2d.a_valid & tl_d.d2h.a_ready & ~full;
        dn_d_hs = tl_d.d2h.d_valid & tl_h.h2d.d_ready;
        pop     = dn_d_hs;
        if (dn_d_hs || empty)                        timer_d = '0;
        else if (timer_q != CntW'(TimeoutCycles))    timer_d = timer_q + 1'b1;
        // A response landing in the threshold cycle still counts as progress.
        if (!dn_d_hs && !empty && timer_q == CntW'(TimeoutCycles - 1)) begin
          state_d   = StFault;
          timeout_d = 1'b1;
          timer_d   = '0;
        end
      end
      StFault: begin
        push    = tl_h.h2d.a_valid & ~full;
        pop     = ~empty & tl_h.h2d.d_ready;
        dn_d_hs = tl_d.d2h.d_valid;
        if (clear_i && empty && dn_pending_q == '0 && !push) begin
          state_d = StActive;
          timer_d = '0;
        end
      end
      default: state_d = StActive;
    endcase
    dn_inc = (state_q == StActive) & push;
    if (dn_inc && !dn_d_hs)                             dn_pending_d = dn_pending_q + 1'b1;
    else if (!dn_inc && dn_d_hs && dn_pending_q != '0)  dn_pending_d = dn_pending_q - 1'b1;
  end

  assign tl_d.h2d  = dn_req;
  assign tl_h.d2h  = up_rsp;
  assign timeout_o = timeout_q;
  assign fault_o   = (state_q == StFault);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StActive;
      timer_q      <= '0;
      dn_pending_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dn_pending_q <= dn_pending_d;
      timeout_q    <= timeout_d;
    end
  end
endmodule

// File: tb/tb_tlul_host_watchdog.sv
// Directed bench for tlul_host_watchdog: pass-through, occupancy cap, timeout, FAULT responses,
// clear handshake, threshold-cycle race and asynchronous reset.
module tb_tlul_host_watchdog;
  import tlul_host_watchdog_pkg::*;

  localparam int unsigned T   = 16;
  localparam int unsigned MAX = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       clear_i;
  logic       timeout_o;
  logic       fault_o;
  logic [2:0] outstanding_o;

  int n_total;
  int n_bad;
  logic [39:0] exp_q[$];

  tlul_host_watchdog_if h_if ();
  tlul_host_watchdog_if d_if ();

  tlul_host_watchdog #(.MaxOutstanding(MAX), .TimeoutCycles(T)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .tl_h          (h_if.slave),
    .tl_d          (d_if.master),
    .clear_i       (clear_i),
    .timeout_o     (timeout_o),
    .fault_o       (fault_o),
    .outstanding_o (outstanding_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic host_idle();
    h_if.h2d         = '0;
    h_if.h2d.d_ready = 1'b1;
  endtask

  task automatic dev_idle();
    d_if.d2h         = '0;
    d_if.d2h.a_ready = 1'b1;
  endtask

  task automatic set_req(input tl_a_op_e op, input logic [7:0] src);
    h_if.h2d.a_valid   = 1'b1;
    h_if.h2d.a_opcode  = op;
    h_if.h2d.a_size    = 2'd2;
    h_if.h2d.a_source  = src;
    h_if.h2d.a_address = {24'h4000_00, src};
    h_if.h2d.a_mask    = 4'hF;
    h_if.h2d.a_data    = {24'hC0FFEE, src};
  endtask

  task automatic set_dev_rsp(input tl_d_op_e op, input logic [7:0] src, input logic [31:0] data);
    d_if.d2h.d_valid  = 1'b1;
    d_if.d2h.d_opcode = op;
    d_if.d2h.d_size   = 2'd2;
    d_if.d2h.d_source = src;
    d_if.d2h.d_data   = data;
    d_if.d2h.d_error  = 1'b0;
  endtask

  // Scoreboard: compare the forwarded response against the oldest expected {source, data}.
  task automatic chk_rsp(input string tag);
    logic [39:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, h_if.d2h.d_valid, 1'b1);
      chk({tag, "_src"},   h_if.d2h.d_source, e[39:32]);
      chk({tag, "_data"},  h_if.d2h.d_data, e[31:0]);
      chk({tag, "_err"},   h_if.d2h.d_error, 1'b0);
    end
  endtask

  initial begin
    logic early;
    n_total = 0;
    n_bad   = 0;
    rst_ni  = 1'b0;
    clear_i = 1'b0;
    host_idle();
    dev_idle();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_fault",   fault_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_occ",     outstanding_o, 3'd0);
    chk("rst_dvalid",  h_if.d2h.d_valid, 1'b0);
    chk("rst_avalid",  d_if.h2d.a_valid, 1'b0);
    rst_ni = 1'b1;
    step();

    // 1: two Gets answered after two cycles each
    set_req(Get, 8'd3);
    exp_q.push_back({8'd3, 32'hA5A5_0003});
    #1;
    chk("t1_fwd_valid", d_if.h2d.a_valid, 1'b1);
    chk("t1_fwd_src",   d_if.h2d.a_source, 8'd3);
    chk("t1_aready",    h_if.d2h.a_ready, 1'b1);
    step();
    chk("t1_occ1", outstanding_o, 3'd1);
    set_req(Get, 8'd5);
    exp_q.push_back({8'd5, 32'h5A5A_0005});
    step();
    host_idle();
    chk("t1_occ2", outstanding_o, 3'd2);
    set_dev_rsp(AccessAckData, 8'd3, 32'hA5A5_0003);
    #1;
    chk_rsp("t1_r3");
    step();
    chk("t1_occ_after1", outstanding_o, 3'd1);
    set_dev_rsp(AccessAckData, 8'd5, 32'h5A5A_0005);
    #1;
    chk_rsp("t1_r5");
    step();
    dev_idle();
    chk("t1_occ0",    outstanding_o, 3'd0);
    chk("t1_timeout", timeout_o, 1'b0);

    // 2: five Gets against a stalled device
    for (int i = 0; i < MAX; i++) begin
      set_req(Get, 8'(10 + i));
      #1;
      chk("t2_aready", h_if.d2h.a_ready, 1'b1);
      step();
    end
    chk("t2_occ4", outstanding_o, 3'd4);
    set_req(Get, 8'd14);
    #1;
    chk("t2_full_aready", h_if.d2h.a_ready, 1'b0);
    chk("t2_full_avalid", d_if.h2d.a_valid, 1'b0);
    step();
    step();
    chk("t2_occ_cap", outstanding_o, 3'd4);
    set_dev_rsp(AccessAckData, 8'd10, 32'h1000_000A);
    #1;
    chk("t2_d_src",        h_if.d2h.d_source, 8'd10);
    chk("t2_aready_at_d",  h_if.d2h.a_ready, 1'b0);
    step();
    dev_idle();
    #1;
    chk("t2_occ3",          outstanding_o, 3'd3);
    chk("t2_aready_after",  h_if.d2h.a_ready, 1'b1);
    step();
    host_idle();
    chk("t2_occ4_again", outstanding_o, 3'd4);
    for (int i = 11; i <= 14; i++) begin
      set_dev_rsp(AccessAckData, 8'(i), 32'h1000_0000 + 32'(i));
      #1;
      chk("t2_drain_src", h_if.d2h.d_source, 8'(i));
      step();
    end
    dev_idle();
    chk("t2_occ0", outstanding_o, 3'd0);

    // 3: a Put to a silent device times out
    set_req(PutFullData, 8'd7);
    step();
    host_idle();
    h_if.h2d.d_ready = 1'b0;
    early = 1'b0;
    for (int i = 1; i < T; i++) begin
      step();
      early = early | timeout_o | fault_o;
    end
    chk("t3_no_early", early, 1'b0);
    step();
    chk("t3_timeout",   timeout_o, 1'b1);
    chk("t3_fault",     fault_o, 1'b1);
    chk("t3_dvalid",    h_if.d2h.d_valid, 1'b1);
    chk("t3_dop",       h_if.d2h.d_opcode, AccessAck);
    chk("t3_dsrc",      h_if.d2h.d_source, 8'd7);
    chk("t3_derr",      h_if.d2h.d_error, 1'b1);
    chk("t3_dn_dready", d_if.h2d.d_ready, 1'b1);
    h_if.h2d.d_ready = 1'b1;
    step();
    chk("t3_pulse_end", timeout_o, 1'b0);
    chk("t3_occ0",      outstanding_o, 3'd0);

    // 4: a Get in FAULT is error-responded locally
    set_req(Get, 8'd2);
    h_if.h2d.d_ready = 1'b0;
    #1;
    chk("t4_not_fwd", d_if.h2d.a_valid, 1'b0);
    chk("t4_aready",  h_if.d2h.a_ready, 1'b1);
    step();
    host_idle();
    h_if.h2d.d_ready = 1'b0;
    #1;
    chk("t4_occ1",   outstanding_o, 3'd1);
    chk("t4_dvalid", h_if.d2h.d_valid, 1'b1);
    chk("t4_dop",    h_if.d2h.d_opcode, AccessAckData);
    chk("t4_dsrc",   h_if.d2h.d_source, 8'd2);
    chk("t4_derr",   h_if.d2h.d_error, 1'b1);
    chk("t4_ddata",  h_if.d2h.d_data, 32'hFFFF_FFFF);
    h_if.h2d.d_ready = 1'b1;
    step();
    chk("t4_occ0",    outstanding_o, 3'd0);
    chk("t4_dvalid0", h_if.d2h.d_valid, 1'b0);

    // 5: clear held while the Put from test 3 is still pending downstream
    clear_i = 1'b1;
    step();
    chk("t5_clear_blocked", fault_o, 1'b1);
    set_dev_rsp(AccessAck, 8'd7, 32'h0);
    #1;
    chk("t5_late_dropped", h_if.d2h.d_valid, 1'b0);
    step();
    dev_idle();
    chk("t5_still_fault", fault_o, 1'b1);
    step();
    chk("t5_cleared", fault_o, 1'b0);
    clear_i = 1'b0;
    set_req(Get, 8'd9);
    #1;
    chk("t5_fwd_valid", d_if.h2d.a_valid, 1'b1);
    chk("t5_fwd_src",   d_if.h2d.a_source, 8'd9);
    step();
    host_idle();
    chk("t5_occ1", outstanding_o, 3'd1);
    set_dev_rsp(AccessAckData, 8'd9, 32'h0909_0909);
    #1;
    chk("t5_rsp_data", h_if.d2h.d_data, 32'h0909_0909);
    chk("t5_rsp_err",  h_if.d2h.d_error, 1'b0);
    step();
    dev_idle();
    chk("t5_occ0", outstanding_o, 3'd0);

    // 6: response in the threshold cycle, then reset mid-burst
    set_req(Get, 8'd4);
    step();
    host_idle();
    early = 1'b0;
    for (int i = 1; i < T; i++) begin
      step();
      early = early | fault_o;
    end
    chk("t6_no_fault_before", early, 1'b0);
    set_dev_rsp(AccessAckData, 8'd4, 32'h4444_4444);
    #1;
    chk("t6_dsrc", h_if.d2h.d_source, 8'd4);
    step();
    dev_idle();
    chk("t6_no_timeout", timeout_o, 1'b0);
    chk("t6_no_fault",   fault_o, 1'b0);
    chk("t6_occ0",       outstanding_o, 3'd0);
    set_req(Get, 8'd1);
    step();
    set_req(Get, 8'd2);
    step();
    host_idle();
    chk("t6_occ2", outstanding_o, 3'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_occ",     outstanding_o, 3'd0);
    chk("t6_rst_fault",   fault_o, 1'b0);
    chk("t6_rst_timeout", timeout_o, 1'b0);
    chk("t6_rst_dvalid",  h_if.d2h.d_valid, 1'b0);
    chk("t6_rst_avalid",  d_if.h2d.a_valid, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step();
    chk("t6_post_aready", h_if.d2h.a_ready, 1'b1);
    chk("t6_post_occ",    outstanding_o, 3'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
